// File: rtl/uart_tx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// scmips_uart_pkg
//   Shared types and constants for the SCMIPS UART transmit path.
//   Contents:
//     UART_DATA_W           - UART character width (8)
//     UART_BAUD_DIV_DEFAULT - sysclk cycles per bit at 100 MHz / 19200 baud
//     tx_state_t            - transmit FSM state encoding
//   Optional feature macro: UART_TX_PARITY_EN. When it is defined, a PARITY
//   state sits between DATA and STOP.
// -----------------------------------------------------------------------------
package scmips_uart_pkg;

  localparam int unsigned UART_DATA_W           = 8;
  localparam int unsigned UART_BAUD_DIV_DEFAULT = 5208;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl_if
//   CPU-side bus of the UART transmitter: the TX data register write strobe
//   and the status bits that feed the memory-mapped UART status register.
//   Signals:
//     wr_en      - one-cycle write strobe for the TX data register
//     wr_data    - byte to transmit
//     ovf_clr    - clears the sticky overflow flag
//     tx_busy    - FSM not idle or FIFO not empty
//     fifo_full  - FIFO-full status
//     fifo_empty - FIFO-empty status
//     overflow   - sticky flag: a write hit a full FIFO
//     tx_done    - one-cycle pulse at the end of each stop bit
//   Modports: master (CPU / bench side), slave (uart_tx_ctrl side).
// -----------------------------------------------------------------------------
interface uart_tx_ctrl_if
  import scmips_uart_pkg::*;
  ;

  logic                   wr_en;
  logic [UART_DATA_W-1:0] wr_data;
  logic                   ovf_clr;
  logic                   tx_busy;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   overflow;
  logic                   tx_done;

  modport master (
    output wr_en, wr_data, ovf_clr,
    input  tx_busy, fifo_full, fifo_empty, overflow, tx_done
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr,
    output tx_busy, fifo_full, fifo_empty, overflow, tx_done
  );

endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//   Byte FIFO that buffers CPU writes for the UART transmitter. It also holds
//   the sticky overflow flag, because only the FIFO knows whether a write was
//   dropped.
//   Parameters:
//     DEPTH - entry count; must be a power of 2 and at least 2
//   Ports:
//     clk_i      - rising-edge clock
//     rst_i      - synchronous active-high reset (pointers, count, flags)
//     wr_en_i    - write request (ignored while full)
//     wr_data_i  - byte to store
//     pop_i      - remove the head entry (ignored while empty)
//     ovf_clr_i  - clear the overflow flag (a same-cycle set wins)
//     rd_data_o  - head entry, valid while empty_o is low
//     full_o     - registered full flag
//     empty_o    - registered empty flag
//     overflow_o - sticky overflow flag
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import scmips_uart_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_en_i,
  input  logic [UART_DATA_W-1:0] wr_data_i,
  input  logic                   pop_i,
  input  logic                   ovf_clr_i,
  output logic [UART_DATA_W-1:0] rd_data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic                   overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CW    = PTR_W + 1;

  logic [UART_DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic                   full_q, empty_q, overflow_q, overflow_d;
  logic                   push_ok, pop_ok;

  // Acceptance uses the registered flags, so a push while full is rejected
  // even when a pop happens in the same cycle.
  assign push_ok = wr_en_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (pop_ok && !push_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (wr_en_i && full_q) begin
      overflow_d = 1'b1;
    end else if (ovf_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  // Storage is not reset; the pointer reset is enough to discard it.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers are exactly log2(DEPTH) bits wide, so they wrap on their own.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      overflow_q <= overflow_d;
    end
  end

  assign rd_data_o  = mem_q[rd_ptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_tx_ctrl
//   Transmit-side UART controller for the SCMIPS peripheral bus. It buffers
//   CPU byte writes in uart_tx_fifo and sends them as 8N1 frames (or 8E1 when
//   UART_TX_PARITY_EN is defined) using an internal baud divider.
//   Parameters:
//     BAUD_DIV   - sysclk cycles per bit (2 or more)
//     FIFO_DEPTH - FIFO entries (power of 2, 2 or more)
//     CNT_W      - baud counter width (2**CNT_W must be at least BAUD_DIV)
//   Ports:
//     sysclk - rising-edge clock
//     reset  - synchronous active-high reset; aborts any frame in flight
//     bus    - CPU write / status interface (slave modport)
//     tx_out - serial line to UART_OUT (idles high)
//   Optional feature macro: UART_TX_PARITY_EN. It adds an even-parity bit
//   between the data bits and the stop bit.
// -----------------------------------------------------------------------------
module uart_tx_ctrl
  import scmips_uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV   = UART_BAUD_DIV_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 13
) (
  input  logic           sysclk,
  input  logic           reset,
  uart_tx_ctrl_if.slave  bus,
  output logic           tx_out
);

  localparam int unsigned IDX_W = $clog2(UART_DATA_W);

  tx_state_t              state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [IDX_W-1:0]       bit_idx_q;
  logic [UART_DATA_W-1:0] shift_q;
  logic                   tx_out_q;
  logic                   tx_done_q;
  logic                   tx_busy_q;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
`endif

  logic [UART_DATA_W-1:0] fifo_rd_data;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   fifo_overflow;
  logic                   fifo_pop;
  logic                   baud_end;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (sysclk),
    .rst_i      (reset),
    .wr_en_i    (bus.wr_en),
    .wr_data_i  (bus.wr_data),
    .pop_i      (fifo_pop),
    .ovf_clr_i  (bus.ovf_clr),
    .rd_data_o  (fifo_rd_data),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_overflow)
  );

  assign fifo_pop = (state_q == IDLE) && !fifo_empty;
  assign baud_end = (cnt_q == CNT_W'(BAUD_DIV - 1));

  // tx_out_q is derived from the state register, so the line lags the FSM
  // by one cycle. That lag is what puts the start bit two edges after the
  // write, and it leaves exactly one high cycle between back-to-back frames.
  // tx_busy_q is also built from registered values, so it drops one cycle
  // after the FSM re-enters IDLE.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_out_q  <= 1'b1;
      tx_done_q <= 1'b0;
      tx_busy_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      tx_done_q <= 1'b0;
      tx_busy_q <= (state_q != IDLE) || !fifo_empty;
      case (state_q)
        IDLE: begin
          tx_out_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q   <= fifo_rd_data;
            cnt_q     <= '0;
            bit_idx_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= ^fifo_rd_data;
`endif
            state_q   <= START;
          end
        end
        START: begin
          tx_out_q <= 1'b0;
          if (baud_end) begin
            cnt_q   <= '0;
            state_q <= DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          tx_out_q <= shift_q[0];
          if (baud_end) begin
            cnt_q <= '0;
            if (bit_idx_q == IDX_W'(UART_DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              shift_q   <= shift_q >> 1;
              bit_idx_q <= bit_idx_q + IDX_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          tx_out_q <= parity_q;
          if (baud_end) begin
            cnt_q   <= '0;
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
`endif
        STOP: begin
          tx_out_q <= 1'b1;
          if (baud_end) begin
            cnt_q     <= '0;
            tx_done_q <= 1'b1;
            state_q   <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          tx_out_q <= 1'b1;
          cnt_q    <= '0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign tx_out         = tx_out_q;
  assign bus.tx_done    = tx_done_q;
  assign bus.tx_busy    = tx_busy_q;
  assign bus.fifo_full  = fifo_full;
  assign bus.fifo_empty = fifo_empty;
  assign bus.overflow   = fifo_overflow;

endmodule
